// File: rtl/mem_access_master.sv
// mem_access_master
//   Turns CPU byte/half/word load-store requests into single-cycle accesses on
//   a word-wide memory with asynchronous read data. Sub-word stores are
//   read-modify-write (READ then WRITE). Out-of-range and reserved-size
//   requests are answered with resp_err and never touch memory.
//
//   Optional build macro: MISALIGN_CHECK_EN
//     defined   -> half with addr[0]=1 or word with addr[1:0]!=0 is an error
//     undefined -> misaligned low address bits are ignored
//
// Ports
//   clk, reset (async, active low)
//   req_valid/req_ready, req_write, req_addr, req_wdata, req_size,
//   req_unsigned                              : CPU request channel
//   resp_valid/resp_ready, resp_rdata, resp_err : CPU response channel
//   mem_addr, mem_din, mem_read, mem_write,
//   mem_dout                                   : memory port
module mem_access_master #(
    parameter int MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    state_t      state, state_nxt;
    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic        a_uns;
    logic        a_write;
    logic [31:0] word_q;   // store data at accept, merged word after READ
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_oob;
    logic        req_misalign;
    logic        req_err;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    assign req_oob = {2'b00, req_addr[31:2]} >= DEPTH_W;

`ifdef MISALIGN_CHECK_EN
    assign req_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_err = (req_size == 2'b11) || req_oob || req_misalign;

    // Lane select / sign extension for loads and lane merge for sub-word
    // stores, both off the word read during READ.
    always_comb begin
        shifted  = mem_dout >> {a_addr[1:0], 3'b000};
        lane_b   = shifted[7:0];
        lane_h   = a_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
        load_ext = mem_dout;
        case (a_size)
            2'b00:   load_ext = {{24{~a_uns & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~a_uns & lane_h[15]}}, lane_h};
            default: load_ext = mem_dout;
        endcase

        merged = mem_dout;
        case (a_size)
            2'b00:   merged[{a_addr[1:0], 3'b000} +: 8]  = word_q[7:0];
            2'b01:   merged[{a_addr[1], 4'b0000} +: 16] = word_q[15:0];
            default: merged = word_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (req_write && (req_size == 2'b10))
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:    state_nxt = a_write ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_addr  <= '0;
            a_size  <= '0;
            a_uns   <= 1'b0;
            a_write <= 1'b0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_addr  <= req_addr;
                        a_size  <= req_size;
                        a_uns   <= req_unsigned;
                        a_write <= req_write;
                        word_q  <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_err;
                    end
                end
                READ: begin
                    if (a_write) word_q  <= merged;
                    else         rdata_q <= load_ext;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Strobes decode straight from state so a reset drops them at once.
    assign mem_read  = (state == READ);
    assign mem_write = (state == WRITE);
    assign mem_addr  = (mem_read || mem_write) ? {a_addr[31:2], 2'b00} : 32'h0;
    assign mem_din   = mem_write ? word_q : 32'h0;

endmodule
